uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Frame-sequencing controller for the UART receiver datapath (sampler, deserializer, start/parity/stop checkers).
//  Detects the start bit and counts oversampling edges and bits per frame, both at Prescale clocks per bit.
//  Issues the per-bit enables to the datapath, then reports frame completion as data_valid, Parity_Error or Stop_Error.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame, sent LSB first
//  PRESCALE_W  6  width of Prescale and edge_cnt
//  BIT_CNT_W   4  width of bit_cnt; must hold DATA_WIDTH+2
// PORTS
//  CLK           in   1           oversampling clock (Prescale x bit rate)
//  RST           in   1           asynchronous reset, active-low
//  RX_IN         in   1           serial line, already synchronized; idle high
//  Prescale      in   PRESCALE_W  clocks per bit; legal 8/16/32
//  PAR_EN        in   1           1 = frame carries a parity bit
//  sampled_bit   in   1           majority-voted bit from sampler; valid at check edge
//  strt_glitch   in   1           start checker result; valid while strt_chk_en=1
//  par_err       in   1           parity checker result; valid while par_chk_en=1
//  stp_err       in   1           stop checker result; valid while stp_chk_en=1
//  data_samp_en  out  1           sampler enable; high in all non-IDLE states
//  edge_cnt      out  PRESCALE_W  current edge within bit, 0..Prescale-1
//  bit_cnt       out  BIT_CNT_W   bit index in frame: start=0, data 1..8, parity 9, stop 9 or 10
//  deser_en      out  1           1-clk pulse: shift sampled_bit into deserializer
//  strt_chk_en   out  1           1-clk pulse at start-bit check edge
//  par_chk_en    out  1           1-clk pulse at parity check edge
//  stp_chk_en    out  1           1-clk pulse at stop check edge
//  data_valid    out  1           1-clk pulse: error-free frame complete
//  Parity_Error  out  1           1-clk pulse at frame end when parity failed
//  Stop_Error    out  1           1-clk pulse at frame end when stop bit was 0
// BEHAVIOUR
//  - Reset (RST=0, any time incl. mid-frame): state=IDLE; counters, error latches and all outputs 0.
//  - P = Prescale latched on IDLE->START. Values outside {8,16,32} are treated as 8. Prescale changes mid-frame are ignored.
//  - Check edge CE = P/2+2 (sampler votes on edges P/2-1..P/2+1, result registered). All *_chk_en/deser_en pulse when edge_cnt==CE.
//  - edge_cnt increments every clk outside IDLE and wraps P-1->0. The wrap increments bit_cnt.
//  - IDLE: RX_IN==0 -> START, edge_cnt=0, bit_cnt=0.
//  - START: at CE strt_chk_en=1. If strt_glitch=1, go to IDLE next clk (no outputs). Else at edge P-1 go to DATA.
//  - DATA: deser_en at CE of each of DATA_WIDTH bits. At edge P-1 of bit_cnt==DATA_WIDTH, go to PARITY if PAR_EN else STOP.
//    PAR_EN is sampled at that transition.
//  - PARITY: par_chk_en at CE; par_err latched into perr_q. At edge P-1 go to STOP.
//  - STOP: stp_chk_en at CE; stp_err latched into serr_q. At edge P-1 go to DONE.
//  - DONE (1 clk): data_valid=!perr_q&&!serr_q, Parity_Error=perr_q, Stop_Error=serr_q; latches cleared.
//    If RX_IN==0: go to START with edge_cnt=1 (this clk is edge 0 of the new start bit). Else go to IDLE.
//  - Latency: frame-end pulse comes exactly (1+DATA_WIDTH+PAR_EN+1)*P clks after the IDLE->START clk.
//  - Simultaneous error and valid: impossible by construction; both errors may pulse together.
//  - Outputs are registered; no combinational path from checker inputs to outputs.
// STRUCTURE
//  - uart_rx_pkg holds the state encoding (IDLE, START, DATA, PARITY, STOP, DONE; 3-bit binary), the legal prescale
//    constants and CE computation function.
//  - Sub-module uart_rx_edge_bit_cnt holds the edge/bit counters. Its controls: enable, load-1 (DONE->START),
//    latched P. Its outputs: edge_cnt, bit_cnt, wrap. The FSM stays in uart_rx_ctrl.
// TESTING
//  1. Glitch: P=8, RX_IN low 1 clk then high. Expect strt_chk_en pulse; drive strt_glitch=1 at CE=6.
//     -> IDLE next clk; no deser_en, no data_valid.
//  2. P=8, PAR_EN=0, data 0x2B LSB first, stop=1.
//     -> 8 deser_en pulses at edge 6, data_valid pulse at clk 80 after start; no errors.
//  3. P=16, PAR_EN=1, data 0xA9, par_err=0, stop=1.
//     -> par_chk_en once, data_valid at clk 176; bit_cnt reaches 10.
//  4. P=8, PAR_EN=1, par_err=1 at parity CE.
//     -> Parity_Error pulse at clk 88, data_valid stays 0. Repeat with stp_err=1 -> Stop_Error only.
//  5. P=32, two frames back-to-back: second start bit begins in the DONE clk.
//     -> second frame accepted, edge_cnt=1 next clk, two data_valid pulses 320 clks apart.
//  6. Reset asserted during DATA bit 4, released after 3 clks.
//     -> all outputs 0 immediately; stays IDLE until next RX_IN falling edge.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types, prescale constants and check-edge helper for the UART RX controller
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Unsupported oversampling ratios fall back to the slowest legal one.
  function automatic int legal_prescale(input int p);
    if (p == PRESCALE_16 || p == PRESCALE_32) return p;
    return PRESCALE_8;
  endfunction

  // Sampler votes on edges P/2-1..P/2+1 and registers the result, so the
  // voted bit is usable two edges after mid-bit.
  function automatic int check_edge(input int p);
    return p / 2 + 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - controller <-> datapath signal bundle for the UART receiver
interface uart_rx_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  sampled_bit;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;

  logic                  data_samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  deser_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
  logic                  Parity_Error;
  logic                  Stop_Error;

  // Controller side.
  modport slave (
    input  RX_IN, Prescale, PAR_EN, sampled_bit, strt_glitch, par_err, stp_err,
    output data_samp_en, edge_cnt, bit_cnt, deser_en, strt_chk_en, par_chk_en,
           stp_chk_en, data_valid, Parity_Error, Stop_Error
  );

  // Line / datapath side.
  modport master (
    output RX_IN, Prescale, PAR_EN, sampled_bit, strt_glitch, par_err, stp_err,
    input  data_samp_en, edge_cnt, bit_cnt, deser_en, strt_chk_en, par_chk_en,
           stp_chk_en, data_valid, Parity_Error, Stop_Error
  );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversampling edge counter and frame bit counter
module uart_rx_edge_bit_cnt #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  load_one,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  wrap
);

  assign wrap = enable && (edge_cnt == prescale - PRESCALE_W'(1));

  // Count edges within a bit; each wrap advances the bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (load_one) begin
      // back-to-back frame: the DONE clock already was edge 0 of the new start bit
      edge_cnt <= PRESCALE_W'(1);
      bit_cnt  <= '0;
    end else if (enable) begin
      if (wrap) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver frame sequencer: start detect, per-bit enables, frame result
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  rx_state_e             state, next_state;
  logic [PRESCALE_W-1:0] p_q;
  logic [PRESCALE_W-1:0] ce;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  wrap, at_ce;
  logic                  cnt_enable, cnt_clear, cnt_load_one;
  logic                  perr_q, serr_q;
  logic                  unused_sampled_bit;

  // sampled_bit feeds the deserializer directly; the sequencer never needs it.
  assign unused_sampled_bit = bus.sampled_bit;

  assign ce         = PRESCALE_W'(check_edge(int'(p_q)));
  assign at_ce      = (edge_cnt == ce);
  assign cnt_enable = (state != IDLE);

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W(PRESCALE_W),
    .BIT_CNT_W (BIT_CNT_W)
  ) u_cnt (
    .clk     (CLK),
    .rst_n   (RST),
    .enable  (cnt_enable),
    .clear   (cnt_clear),
    .load_one(cnt_load_one),
    .prescale(p_q),
    .edge_cnt(edge_cnt),
    .bit_cnt (bit_cnt),
    .wrap    (wrap)
  );

  // Next-state logic and counter controls.
  always_comb begin
    next_state   = state;
    cnt_clear    = 1'b0;
    cnt_load_one = 1'b0;
    case (state)
      IDLE:    if (!bus.RX_IN) next_state = START;
      START: begin
        if (at_ce && bus.strt_glitch) next_state = IDLE;
        else if (wrap)                next_state = DATA;
      end
      DATA:    if (wrap && bit_cnt == BIT_CNT_W'(DATA_WIDTH))
                 next_state = bus.PAR_EN ? PARITY : STOP;
      PARITY:  if (wrap) next_state = STOP;
      STOP:    if (wrap) next_state = DONE;
      DONE:    next_state = bus.RX_IN ? IDLE : START;
      default: next_state = IDLE;
    endcase
    cnt_clear    = (next_state == IDLE);
    cnt_load_one = (state == DONE) && (next_state == START);
  end

  // State, per-frame prescale and checker result latches.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      p_q    <= PRESCALE_W'(PRESCALE_8);
      perr_q <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == START && state != START)
        p_q <= PRESCALE_W'(legal_prescale(int'(bus.Prescale)));
      if (state == DONE) begin
        perr_q <= 1'b0;
        serr_q <= 1'b0;
      end else begin
        if (state == PARITY && at_ce) perr_q <= bus.par_err;
        if (state == STOP && at_ce)   serr_q <= bus.stp_err;
      end
    end
  end

  // All outputs decode registered state only, so checker inputs never reach them combinationally.
  assign bus.data_samp_en = (state != IDLE);
  assign bus.edge_cnt     = edge_cnt;
  assign bus.bit_cnt      = bit_cnt;
  assign bus.strt_chk_en  = (state == START)  && at_ce;
  assign bus.deser_en     = (state == DATA)   && at_ce;
  assign bus.par_chk_en   = (state == PARITY) && at_ce;
  assign bus.stp_chk_en   = (state == STOP)   && at_ce;
  assign bus.data_valid   = (state == DONE) && !perr_q && !serr_q;
  assign bus.Parity_Error = (state == DONE) && perr_q;
  assign bus.Stop_Error   = (state == DONE) && serr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard testbench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  localparam logic [6:0] M_STRT  = 7'b1000000;
  localparam logic [6:0] M_DESER = 7'b0100000;
  localparam logic [6:0] M_PAR   = 7'b0010000;
  localparam logic [6:0] M_STP   = 7'b0001000;
  localparam logic [6:0] M_VALID = 7'b0000100;
  localparam logic [6:0] M_PERR  = 7'b0000010;
  localparam logic [6:0] M_SERR  = 7'b0000001;

  typedef struct {
    int         cyc;
    logic [6:0] mask;
    logic [5:0] edge_v;
    logic [3:0] bit_v;
    logic [7:0] data;
    bit         is_end;
  } exp_t;

  logic CLK;
  logic RST;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t cur;
  logic [6:0] pulses;
  logic [7:0] shreg;
  int   t0;

  uart_rx_if #(.PRESCALE_W(6), .BIT_CNT_W(4)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  assign bus.sampled_bit = bus.RX_IN;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] pulses_now();
    return {bus.strt_chk_en, bus.deser_en, bus.par_chk_en, bus.stp_chk_en,
            bus.data_valid, bus.Parity_Error, bus.Stop_Error};
  endfunction

  task automatic push(input int c, input logic [6:0] m, input logic [5:0] e,
                      input logic [3:0] b, input logic [7:0] d, input bit is_end);
    exp_t x;
    x.cyc = c; x.mask = m; x.edge_v = e; x.bit_v = b; x.data = d; x.is_end = is_end;
    sb.push_back(x);
  endtask

  // Drive one frame on the line and queue every pulse it must produce.
  task automatic send_frame(input int p_drive, input bit pe, input logic [7:0] d,
                            input bit perr, input bit serr);
    int p, ce, t, nb;
    logic [6:0] endm;
    p  = (p_drive == 8 || p_drive == 16 || p_drive == 32) ? p_drive : 8;
    ce = p / 2 + 2;
    t  = cyc + 1;
    nb = 10 + int'(pe);
    push(t + ce, M_STRT, 6'(ce), 4'd0, 8'd0, 1'b0);
    for (int b = 1; b <= 8; b++) push(t + b * p + ce, M_DESER, 6'(ce), 4'(b), 8'd0, 1'b0);
    if (pe) push(t + 9 * p + ce, M_PAR, 6'(ce), 4'd9, 8'd0, 1'b0);
    push(t + (nb - 1) * p + ce, M_STP, 6'(ce), 4'(nb - 1), 8'd0, 1'b0);
    if ((pe && perr) || serr)
      endm = ((pe && perr) ? M_PERR : 7'd0) | (serr ? M_SERR : 7'd0);
    else
      endm = M_VALID;
    push(t + nb * p, endm, 6'd0, 4'(nb), d, 1'b1);
    bus.Prescale = 6'(p_drive);
    bus.PAR_EN   = pe;
    bus.par_err  = perr;
    bus.stp_err  = serr;
    bus.RX_IN    = 1'b0;
    repeat (p) @(negedge CLK);
    // a mid-frame prescale change must not disturb the frame in flight
    bus.Prescale = (p == 16) ? 6'd8 : 6'd16;
    for (int b = 0; b < 8; b++) begin
      bus.RX_IN = d[b];
      repeat (p) @(negedge CLK);
    end
    if (pe) begin
      bus.RX_IN = (^d) ^ perr;
      repeat (p) @(negedge CLK);
    end
    bus.RX_IN = !serr;
    repeat (p) @(negedge CLK);
    bus.RX_IN = 1'b1;
  endtask

  // Monitor: every output pulse pops the next expectation.
  initial begin
    shreg = 8'd0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        pulses = pulses_now();
        if (bus.deser_en) shreg = {bus.RX_IN, shreg[7:1]};
        if (pulses != 7'd0) begin
          if (sb.size() == 0) begin
            chk("unexpected_pulse", int'(pulses), 0);
          end else begin
            cur = sb.pop_front();
            chk("pulse_mask", int'(pulses), int'(cur.mask));
            chk("pulse_cycle", cyc, cur.cyc);
            chk("pulse_edge_bit", int'({bus.edge_cnt, bus.bit_cnt}), int'({cur.edge_v, cur.bit_v}));
            if (cur.is_end) chk("frame_data", int'(shreg), int'(cur.data));
          end
        end
      end
    end
  end

  initial begin
    cyc = 0; checks = 0; errors = 0;
    RST = 1'b0;
    bus.RX_IN = 1'b1; bus.Prescale = 6'd8; bus.PAR_EN = 1'b0;
    bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_samp_en", int'(bus.data_samp_en), 0);
    chk("reset_counters", int'({bus.edge_cnt, bus.bit_cnt}), 0);
    chk("reset_pulses", int'(pulses_now()), 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // start glitch: one low clock, checker reports glitch at edge 6
    t0 = cyc + 1;
    push(t0 + 6, M_STRT, 6'd6, 4'd0, 8'd0, 1'b0);
    bus.Prescale = 6'd8; bus.strt_glitch = 1'b1; bus.RX_IN = 1'b0;
    @(negedge CLK);
    bus.RX_IN = 1'b1;
    while (cyc < t0 + 7) @(negedge CLK);
    chk("glitch_idle", int'(bus.data_samp_en), 0);
    chk("glitch_edge_cnt", int'(bus.edge_cnt), 0);
    repeat (16) @(negedge CLK);
    bus.strt_glitch = 1'b0;

    send_frame(8, 1'b0, 8'h2B, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    send_frame(16, 1'b1, 8'hA9, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    send_frame(8, 1'b1, 8'h3C, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    send_frame(8, 1'b1, 8'h3C, 1'b0, 1'b1);
    repeat (4) @(negedge CLK);
    send_frame(8, 1'b1, 8'h81, 1'b1, 1'b1);
    repeat (4) @(negedge CLK);
    send_frame(8, 1'b0, 8'h66, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    send_frame(12, 1'b0, 8'h96, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);

    // back-to-back frames at P=32
    t0 = cyc + 1;
    fork
      begin
        send_frame(32, 1'b0, 8'h55, 1'b0, 1'b0);
        send_frame(32, 1'b0, 8'hC3, 1'b0, 1'b0);
      end
      begin
        while (cyc < t0 + 321) @(negedge CLK);
        chk("b2b_edge_cnt", int'(bus.edge_cnt), 1);
        chk("b2b_in_frame", int'(bus.data_samp_en), 1);
      end
    join
    repeat (4) @(negedge CLK);

    // reset during data bit 4
    t0 = cyc + 1;
    push(t0 + 6, M_STRT, 6'd6, 4'd0, 8'd0, 1'b0);
    for (int b = 1; b <= 3; b++) push(t0 + 8 * b + 6, M_DESER, 6'd6, 4'(b), 8'd0, 1'b0);
    bus.Prescale = 6'd8; bus.PAR_EN = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
    bus.RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    for (int b = 0; b < 3; b++) begin
      bus.RX_IN = b[0];
      repeat (8) @(negedge CLK);
    end
    bus.RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("pre_reset_bit_cnt", int'(bus.bit_cnt), 4);
    chk("pre_reset_edge_cnt", int'(bus.edge_cnt), 2);
    RST = 1'b0;
    #1;
    chk("midreset_samp_en", int'(bus.data_samp_en), 0);
    chk("midreset_counters", int'({bus.edge_cnt, bus.bit_cnt}), 0);
    chk("midreset_pulses", int'(pulses_now()), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (20) @(negedge CLK);
    chk("post_reset_idle", int'(bus.data_samp_en), 0);
    chk("post_reset_counters", int'({bus.edge_cnt, bus.bit_cnt}), 0);
    send_frame(16, 1'b0, 8'h0F, 1'b0, 1'b0);

    repeat (10) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
